// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_pkg;

    localparam int FETCH_DEPTH_DEFAULT = 4;
    localparam int FETCH_CNT_W         = $clog2(FETCH_DEPTH_DEFAULT) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with same-cycle push/pop and
// a flush that empties it. Storage resets to a NOP at PC 0 so the head is defined.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t       mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               do_push_s;
    logic               do_pop_s;

    // Gate push/pop: a flush voids both, and an empty FIFO cannot be popped.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush_i) begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else begin
            do_push_s = push_i;
            do_pop_s  = pop_i && (count_r != {CNT_W{1'b0}});
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{pc: 32'h0000_0000, instr: INSTR_NOP};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data_i;
        end
    end

    assign head_o  = mem_r[rd_ptr_r];
    assign valid_o = (count_r != {CNT_W{1'b0}});
    assign count_o = count_r;

endmodule

// File: rtl/instr_fetch_queue.sv
// Decoupled fetch stage: credit-limited word fetches, in-order response capture
// into a FIFO, and redirect handling that flushes and squashes in-flight fetches.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = FETCH_DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic [31:0] instr_pc4_o,
    input  logic        instr_ready_i
);

    localparam int               CNT_W        = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] DISCARD_MAX  = CNT_W'(DEPTH);

    logic [31:0]      fetch_pc_r;
    logic [31:0]      rsp_pc_r;
    logic [CNT_W-1:0] outstanding_r;
    logic [CNT_W-1:0] discard_r;

    logic [CNT_W-1:0] occupancy_s;
    logic [CNT_W:0]   inflight_s;
    logic             grant_s;
    logic             rsp_s;
    logic             drop_s;
    logic             push_s;
    logic             pop_s;
    logic [31:0]      redirect_pc_s;
    logic [CNT_W-1:0] outstanding_next_s;
    logic [CNT_W-1:0] discard_next_s;
    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_s;

    // Credit check, handshakes and next-count arithmetic.
    always_comb begin
        inflight_s    = {1'b0, occupancy_s} + {1'b0, outstanding_r};
        mem_req_o     = !rst_i && !redirect_valid_i && (inflight_s < CREDIT_LIMIT);
        grant_s       = mem_req_o && mem_gnt_i;
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp_s         = mem_rvalid_i && (outstanding_r != {CNT_W{1'b0}});
        drop_s        = rsp_s && (discard_r != {CNT_W{1'b0}});
        push_s        = rsp_s && !drop_s && !redirect_valid_i;
        pop_s         = instr_valid_o && instr_ready_i && !redirect_valid_i;
        redirect_pc_s = redirect_pc_i & 32'hFFFF_FFFC;
        push_entry_s  = '{pc: rsp_pc_r, instr: mem_rdata_i};
        outstanding_next_s = outstanding_r + CNT_W'(grant_s) - CNT_W'(rsp_s);
        // On redirect everything still in flight after this cycle is stale;
        // the request line is low then, so grant_s never adds a new fetch.
        if (redirect_valid_i) begin
            discard_next_s = (outstanding_next_s > DISCARD_MAX) ? DISCARD_MAX : outstanding_next_s;
        end else begin
            discard_next_s = discard_r - CNT_W'(drop_s);
        end
    end

    // PC, credit and discard state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= {CNT_W{1'b0}};
            discard_r     <= {CNT_W{1'b0}};
        end else begin
            outstanding_r <= outstanding_next_s;
            discard_r     <= discard_next_s;
            if (redirect_valid_i) begin
                fetch_pc_r <= redirect_pc_s;
                rsp_pc_r   <= redirect_pc_s;
            end else begin
                if (grant_s) begin
                    fetch_pc_r <= fetch_pc_r + 32'd4;
                end
                if (push_s) begin
                    rsp_pc_r <= rsp_pc_r + 32'd4;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (redirect_valid_i),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .valid_o     (instr_valid_o),
        .count_o     (occupancy_s)
    );

    assign mem_addr_o  = fetch_pc_r;
    assign instr_o     = head_s.instr;
    assign instr_pc_o  = head_s.pc;
    assign instr_pc4_o = head_s.pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: in-order memory model plus a scoreboard
// of expected {pc, instr} entries, checked with immediate assertions.
module tb_instr_fetch_queue;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [31:0] instr_pc4_o;
    logic        instr_ready_i;

    always #5 clk_i = ~clk_i;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_gnt_i        (mem_gnt_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_pc4_o      (instr_pc4_o),
        .instr_ready_i    (instr_ready_i)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    pend_t        pend[$];
    fetch_entry_t sb[$];
    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    int           lat   = 1;
    int           grants;
    logic         gnt_v   = 1'b0;
    logic         ready_v = 1'b0;
    logic [31:0]  exp_fetch_pc = RESET_PC;
    logic         s_req, s_valid;
    logic [31:0]  s_addr, s_pc, s_pc4, s_instr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive memory response, check outputs mid-cycle, update model at the edge.
    task automatic tick();
        pend_t        p;
        fetch_entry_t e;
        logic         exp_req;
        logic         rv;
        logic         do_pop;
        rv = 1'b0;
        if (!rst_i && pend.size() > 0) begin
            if (pend[0].due <= cyc) rv = 1'b1;
        end
        mem_rvalid_i  = rv;
        mem_rdata_i   = rv ? instr_of(pend[0].addr) : 32'h0000_0000;
        mem_gnt_i     = gnt_v;
        instr_ready_i = ready_v;
        @(negedge clk_i);
        s_req   = mem_req_o;
        s_addr  = mem_addr_o;
        s_valid = instr_valid_o;
        s_pc    = instr_pc_o;
        s_pc4   = instr_pc4_o;
        s_instr = instr_o;
        exp_req = !rst_i && !redirect_valid_i && ((sb.size() + pend.size()) < DEPTH);
        chk("req", {31'd0, s_req}, {31'd0, exp_req});
        chk("addr", s_addr, exp_fetch_pc);
        chk("valid", {31'd0, s_valid}, {31'd0, sb.size() > 0});
        if (sb.size() > 0) begin
            chk("head_pc", s_pc, sb[0].pc);
            chk("head_instr", s_instr, sb[0].instr);
            chk("head_pc4", s_pc4, sb[0].pc + 32'd4);
        end
        do_pop = (sb.size() > 0) && ready_v && !redirect_valid_i && !rst_i;
        @(posedge clk_i);
        if (rst_i) begin
            pend.delete();
            sb.delete();
            exp_fetch_pc = RESET_PC;
        end else begin
            if (do_pop) e = sb.pop_front();
            if (rv) begin
                p = pend.pop_front();
                if (!p.stale && !redirect_valid_i) sb.push_back('{pc: p.addr, instr: instr_of(p.addr)});
            end
            if (redirect_valid_i) begin
                sb.delete();
                foreach (pend[i]) pend[i].stale = 1'b1;
                exp_fetch_pc = redirect_pc_i & 32'hFFFF_FFFC;
            end else if (exp_req && gnt_v) begin
                pend.push_back('{addr: exp_fetch_pc, due: cyc + lat, stale: 1'b0});
                exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
        end
        #1;
        cyc++;
    endtask

    task automatic drain();
        gnt_v   = 1'b0;
        ready_v = 1'b1;
        repeat (8) tick();
    endtask

    task automatic wait_first(input string tag, input logic [31:0] exp_pc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (s_valid) begin
                found = 1'b1;
                chk(tag, s_pc, exp_pc);
            end
        end
        if (!found) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic redirect_stale(input logic [31:0] tgt, input logic [31:0] exp_pc);
        drain();
        ready_v = 1'b0;
        lat = 1; gnt_v = 1'b1; tick();
        lat = 3; tick();
        tick();
        gnt_v = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = tgt;
        tick();
        redirect_valid_i = 1'b0; gnt_v = 1'b1; lat = 1; ready_v = 1'b1;
        tick();
        chk("redir_valid_drop", {31'd0, s_valid}, 32'd0);
        chk("redir_addr", s_addr, exp_pc);
        wait_first("redir_first_pc", exp_pc);
    endtask

    initial begin
        rst_i = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; instr_ready_i = 1'b0;
        @(posedge clk_i); #1;
        repeat (2) tick();
        chk("rst_req", {31'd0, s_req}, 32'd0);
        chk("rst_addr", s_addr, RESET_PC);
        chk("rst_valid", {31'd0, s_valid}, 32'd0);
        chk("rst_instr", s_instr, 32'h0);
        chk("rst_pc", s_pc, 32'h0);
        chk("rst_pc4", s_pc4, 32'h4);

        // Streaming at one instruction per cycle.
        rst_i = 1'b0; gnt_v = 1'b1; ready_v = 1'b1; lat = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t1_req", {31'd0, s_req}, 32'd1);
            chk("t1_addr", s_addr, 32'(4 * k));
            if (k >= 2) begin
                chk("t1_valid", {31'd0, s_valid}, 32'd1);
                chk("t1_pc", s_pc, 32'(4 * (k - 2)));
                chk("t1_pc4", s_pc4, 32'(4 * (k - 1)));
            end else begin
                chk("t1_valid", {31'd0, s_valid}, 32'd0);
            end
        end

        // Credit limit with a stalled consumer.
        drain();
        ready_v = 1'b0; gnt_v = 1'b1; grants = 0;
        repeat (10) begin tick(); if (s_req) grants++; end
        chk("t2_grants", 32'(grants), 32'd4);
        chk("t2_req_low", {31'd0, s_req}, 32'd0);
        chk("t2_full", {31'd0, s_valid}, 32'd1);
        ready_v = 1'b1; tick(); ready_v = 1'b0; grants = 0;
        repeat (6) begin tick(); if (s_req) grants++; end
        chk("t2_one_more", 32'(grants), 32'd1);

        // Address held while grant is withheld.
        drain();
        begin
            logic [31:0] a0;
            a0 = exp_fetch_pc;
            repeat (3) begin
                tick();
                chk("t3_req", {31'd0, s_req}, 32'd1);
                chk("t3_hold", s_addr, a0);
            end
            gnt_v = 1'b1; tick();
            chk("t3_gnt_addr", s_addr, a0);
            gnt_v = 1'b0; tick();
            chk("t3_adv", s_addr, a0 + 32'd4);
        end

        // Redirect with stale fetches in flight, aligned and unaligned targets.
        redirect_stale(32'h0000_0100, 32'h0000_0100);
        redirect_stale(32'h0000_0103, 32'h0000_0100);

        // Redirect coinciding with grant and response.
        drain();
        lat = 2; gnt_v = 1'b1; ready_v = 1'b1;
        repeat (5) tick();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        tick();
        redirect_valid_i = 1'b0; lat = 1;
        wait_first("t5_first_pc", 32'h0000_0200);
        repeat (4) tick();

        // PC wrap at the top of the address space.
        drain();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; gnt_v = 1'b1; lat = 1;
        tick();
        redirect_valid_i = 1'b0;
        tick();
        chk("t6_addr", s_addr, 32'hFFFF_FFFC);
        tick();
        chk("t6_wrap", s_addr, 32'h0000_0000);
        tick();
        chk("t6_valid", {31'd0, s_valid}, 32'd1);
        chk("t6_pc", s_pc, 32'hFFFF_FFFC);
        chk("t6_pc4", s_pc4, 32'h0000_0000);

        // Reset in the middle of traffic.
        ready_v = 1'b0;
        repeat (3) tick();
        rst_i = 1'b1;
        repeat (2) tick();
        chk("t7_valid", {31'd0, s_valid}, 32'd0);
        chk("t7_addr", s_addr, RESET_PC);
        chk("t7_pc4", s_pc4, 32'h4);
        rst_i = 1'b0; ready_v = 1'b1;
        tick();
        chk("t7_restart", s_addr, RESET_PC);
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
